// File: rtl/day_pkg.sv
// Shared state type and fixed day-code table for the day sequencer.
package day_pkg;

  localparam int MAX_DAYS = 8;

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} seq_state_t;

  // Codes are {A,B,C,D}, A is the MSB; entries past NUM_DAYS are never driven.
  localparam logic [3:0] DAY_CODE [MAX_DAYS] = '{
    4'b0010, 4'b1011, 4'b1111, 4'b1010,
    4'b1100, 4'b0000, 4'b0000, 4'b0000
  };

endpackage

// File: rtl/day_sequencer_if.sv
// Decoder drive and result stream between the day sequencer and its environment.
interface day_sequencer_if;

  logic       start;
  logic       X, Y, Z;
  logic       A, B, C, D;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_day_idx;
  logic [2:0] res_zyx;
  logic       busy;
  logic       done;

  modport master (
    input  start, X, Y, Z, res_ready,
    output A, B, C, D, res_valid, res_day_idx, res_zyx, busy, done
  );

  modport slave (
    output start, X, Y, Z, res_ready,
    input  A, B, C, D, res_valid, res_day_idx, res_zyx, busy, done
  );

endinterface

// File: rtl/hold_counter.sv
// Counts cycles a day code has been held; stops at HOLD_CYCLES-1 and flags it.
// Clear wins over enable; the count never wraps.
module hold_counter #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/day_sequencer.sv
// Steps the day-code table onto the decoder, samples {Z,Y,X} after HOLD_CYCLES and
// streams one result per day; res_ready low stalls in EMIT with code and result frozen.
module day_sequencer
  import day_pkg::*;
#(
  parameter int NUM_DAYS    = 5,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  day_sequencer_if.master bus
);

  if (NUM_DAYS < 1 || NUM_DAYS > MAX_DAYS || HOLD_CYCLES < 1) begin : g_param_check
    $error("day_sequencer: NUM_DAYS must be 1..MAX_DAYS and HOLD_CYCLES >= 1");
  end

  localparam logic [2:0] LAST_IDX = 3'(NUM_DAYS - 1);

  seq_state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] code_q, code_d;
  logic       res_vld_q, res_vld_d;
  logic [2:0] res_idx_q, res_idx_d;
  logic [2:0] res_zyx_q, res_zyx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cnt_clr, cnt_en, cnt_tc;

  hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      code_q    <= '0;
      res_vld_q <= 1'b0;
      res_idx_q <= '0;
      res_zyx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      res_vld_q <= res_vld_d;
      res_idx_q <= res_idx_d;
      res_zyx_q <= res_zyx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = DRIVE;
      DRIVE:      if (cnt_tc) state_d = EMIT;
      EMIT: begin
        if (bus.res_ready) state_d = (idx_q == LAST_IDX) ? DONE : DRIVE;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    code_d    = code_q;
    res_vld_d = res_vld_q;
    res_idx_d = res_idx_q;
    res_zyx_d = res_zyx_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          idx_d   = '0;
          code_d  = DAY_CODE[3'd0];
          cnt_clr = 1'b1;
        end
      end
      DRIVE: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          res_zyx_d = {bus.Z, bus.Y, bus.X};
          res_idx_d = idx_q;
          res_vld_d = 1'b1;
        end
      end
      EMIT: begin
        if (bus.res_ready) begin
          res_vld_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            code_d = '0;
          end else begin
            idx_d   = idx_q + 3'd1;
            code_d  = DAY_CODE[idx_q + 3'd1];
            cnt_clr = 1'b1;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d == DRIVE) || (state_d == EMIT);
    done_d = (state_d == DONE);
  end

  assign {bus.A, bus.B, bus.C, bus.D} = code_q;
  assign bus.res_valid   = res_vld_q;
  assign bus.res_day_idx = res_idx_q;
  assign bus.res_zyx     = res_zyx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_day_sequencer.sv
// Bench for day_sequencer with a stub decoder {Z,Y,X} = {B,C,D}.
module tb_day_sequencer;

  localparam int N = 5;
  localparam int H = 2;
  localparam logic [3:0] REF_CODE [5] = '{4'b0010, 4'b1011, 4'b1111, 4'b1010, 4'b1100};

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_idx[$];

  always #5 clk = ~clk;

  day_sequencer_if bus();
  day_sequencer_if bus1();

  assign bus.Z  = bus.B;
  assign bus.Y  = bus.C;
  assign bus.X  = bus.D;
  assign bus1.Z = bus1.B;
  assign bus1.Y = bus1.C;
  assign bus1.X = bus1.D;

  day_sequencer #(.NUM_DAYS(N), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  day_sequencer #(.NUM_DAYS(1), .HOLD_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Handshakes seen mid-cycle complete on the following rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1)
      hs_idx.push_back(int'(bus.res_day_idx));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;  bus.res_ready = 1'b0;
    bus1.start = 1'b0; bus1.res_ready = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({bus.A, bus.B, bus.C, bus.D} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_code got %b want 0000", {bus.A, bus.B, bus.C, bus.D});
    end
    n_tests++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", bus.res_valid);
    end
    n_tests++;
    if (bus.res_day_idx !== 3'd0 || bus.res_zyx !== 3'd0) begin
      n_fail++; $display("FAIL reset_result got idx=%0d zyx=%b want 0/000", bus.res_day_idx, bus.res_zyx);
    end
    n_tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_status got busy/done=%b want 00", {bus.busy, bus.done});
    end
    n_tests++;
    if ({bus1.busy, bus1.done, bus1.res_valid, bus1.A, bus1.B, bus1.C, bus1.D} !== 7'd0) begin
      n_fail++; $display("FAIL reset_small got %b want 0000000",
                         {bus1.busy, bus1.done, bus1.res_valid, bus1.A, bus1.B, bus1.C, bus1.D});
    end
    rst = 1'b0;
    tick();
  endtask

  // Model: after the edge that enters day k at edge t0, res_valid is up from t0+H until
  // the handshake edge, the code is REF_CODE[k], and after the last handshake all idles.
  task automatic run_and_check(input string name, input int ready_pct, input int spur_mode,
                               input int bp_day, input int bp_len);
    int k, t0, e, pre;
    bit fin, rdy, spur, ok;
    logic exp_v;
    logic [12:0] obs, expv;
    hs_idx.delete();
    bus.res_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0; t0 = 0; e = 0; fin = 1'b0;
    while (!fin) begin
      if (k == N) begin
        expv = 13'b0_1_0_0000_000_000;
      end else begin
        exp_v = ((e - t0) >= H);
        expv = {1'b1, 1'b0, exp_v, REF_CODE[k],
                exp_v ? 3'(k) : 3'b000, exp_v ? REF_CODE[k][2:0] : 3'b000};
      end
      obs = {bus.busy, bus.done, bus.res_valid, bus.A, bus.B, bus.C, bus.D,
             bus.res_valid ? bus.res_day_idx : 3'b000,
             bus.res_valid ? bus.res_zyx : 3'b000};
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s edge %0d: got busy,done,vld,ABCD,idx,zyx=%b want %b", name, e, obs, expv);
      end
      if (k == N) begin
        fin = 1'b1;
      end else if (e >= 400) begin
        n_tests++; n_fail++;
        $display("FAIL %s_timeout: got %0d results want %0d", name, k, N);
        fin = 1'b1;
      end else begin
        pre  = e - t0;
        rdy  = ($urandom_range(99) < ready_pct);
        if (k == bp_day && pre >= H && pre < H + bp_len) rdy = 1'b0;
        spur = (spur_mode == 1 && k == 2 && pre == 0) ||
               (spur_mode == 2 && $urandom_range(3) == 0);
        bus.res_ready = rdy;
        bus.start = spur;
        tick();
        e++;
        bus.start = 1'b0;
        if (pre >= H && rdy) begin
          k++;
          t0 = e;
        end
      end
    end
    bus.res_ready = 1'b1;
    if (ready_pct == 100 && bp_len == 0) begin
      n_tests++;
      if (e !== N * (H + 1)) begin
        n_fail++; $display("FAIL %s_done_edge got %0d want %0d", name, e, N * (H + 1));
      end
    end
    ok = (hs_idx.size() == N);
    for (int i = 0; i < hs_idx.size(); i++) if (hs_idx[i] != i) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL %s_handshakes got %0d (order ok=0) want %0d in order", name, hs_idx.size(), N);
    end
  endtask

  task automatic test_mid_run_reset();
    bus.res_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.res_valid, bus.A, bus.B, bus.C, bus.D} !== 7'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs got %b want 0000000",
                         {bus.busy, bus.done, bus.res_valid, bus.A, bus.B, bus.C, bus.D});
    end
    #1;
    rst = 1'b0;
    tick();
    run_and_check("post_reset_run", 100, 0, -1, 0);
  endtask

  task automatic test_small_params();
    bus1.res_ready = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    n_tests++;
    if ({bus1.busy, bus1.res_valid, bus1.A, bus1.B, bus1.C, bus1.D} !== 6'b10_0010) begin
      n_fail++; $display("FAIL small_edge0 got %b want 100010",
                         {bus1.busy, bus1.res_valid, bus1.A, bus1.B, bus1.C, bus1.D});
    end
    tick();
    n_tests++;
    if ({bus1.res_valid, bus1.res_zyx, bus1.res_day_idx} !== 7'b1_010_000) begin
      n_fail++; $display("FAIL small_result got %b want 1010000",
                         {bus1.res_valid, bus1.res_zyx, bus1.res_day_idx});
    end
    tick();
    n_tests++;
    if ({bus1.busy, bus1.done, bus1.res_valid, bus1.A, bus1.B, bus1.C, bus1.D} !== 7'b01_0_0000) begin
      n_fail++; $display("FAIL small_done got %b want 0100000",
                         {bus1.busy, bus1.done, bus1.res_valid, bus1.A, bus1.B, bus1.C, bus1.D});
    end
  endtask

  initial begin
    test_reset();
    run_and_check("full_run", 100, 0, -1, 0);
    run_and_check("backpressure", 100, 0, 1, 6);
    run_and_check("spurious_start", 100, 1, -1, 0);
    run_and_check("restart_from_done", 100, 0, -1, 0);
    for (int r = 0; r < 4; r++) run_and_check("random_ready", 50, 2, -1, 0);
    test_mid_run_reset();
    test_small_params();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
